// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, the NOP instruction byte and the
// program loader state encoding.
package cpu_pkg;

  // Instruction byte layout: opcode [7:3], register/operand field [2:0]
  localparam logic [4:0] OP_NOP          = 5'b00000;
  localparam logic [4:0] OP_MOV_RX_R0    = 5'b00001;
  localparam logic [4:0] OP_MOV_CONST_R0 = 5'b00010;
  localparam logic [4:0] OP_MOV_R0_RX    = 5'b00011;
  localparam logic [4:0] OP_NOT          = 5'b00111;
  localparam logic [4:0] OP_AND          = 5'b01000;
  localparam logic [4:0] OP_OR           = 5'b01001;
  localparam logic [4:0] OP_XOR          = 5'b01010;
  localparam logic [4:0] OP_ADD          = 5'b01011;
  localparam logic [4:0] OP_SUB          = 5'b01100;

  // Byte presented to the fetch port whenever no complete image is resident
  localparam logic [7:0] NOP_BYTE = 8'h00;

  // Loader FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } ld_state_e;

endpackage

// File: rtl/program_memory_instr_ram.sv
// Instruction storage: one synchronous write port, one asynchronous read
// port. No reset on the array so an image survives a system reset.
module instr_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port: byte lands on the rising edge, readable from the next cycle
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read port is purely combinational (zero-latency fetch)
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/program_memory.sv
// Instruction memory plus boot loader. Streams a program image in over a
// valid/ready handshake, holds the CPU in reset and shows NOP on the fetch
// port until the whole image is resident, then serves fetches combinationally.
module program_memory
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memVal,
  input  logic                  loadStart,
  input  logic [ADDR_WIDTH-1:0] loadLen,
  input  logic [DATA_WIDTH-1:0] loadData,
  input  logic                  loadValid,
  output logic                  loadReady,
  output logic                  loadDone,
  output logic                  cpuRst
);

  ld_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  // One extra bit so a full-depth image (loadLen == 0) fits the counter
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic                  done_q, done_d;
  logic                  cpu_rst_q;
  logic                  ready_q;
  logic                  wr_en;
  logic [ADDR_WIDTH:0]   start_count;
  logic [DATA_WIDTH-1:0] rd_data;

  // loadLen == 0 encodes 2**ADDR_WIDTH: the MSB is set exactly in that case
  assign start_count = {(loadLen == '0), loadLen};

  // Next-state logic: start/restart a load, count accepted bytes, finish
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        // Any loadValid this cycle is dropped: ready is low outside LOAD
        if (loadStart) begin
          state_d     = LOAD;
          wr_ptr_d    = '0;
          remaining_d = start_count;
        end
      end
      LOAD: begin
        // loadStart is ignored here; the latched length stands
        if (loadValid) begin
          wr_en       = 1'b1;
          wr_ptr_d    = wr_ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
            state_d = RUN;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered control outputs; rst wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      cpu_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      cpu_rst_q   <= (state_d != RUN);
      ready_q     <= (state_d == LOAD);
    end
  end

  // A byte offered in the same cycle as rst is not written
  instr_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en & ~rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (loadData),
    .raddr_i (memAddr),
    .rdata_o (rd_data)
  );

  assign loadReady = ready_q;
  assign loadDone  = done_q;
  assign cpuRst    = cpu_rst_q;
  // Fetch sees NOP unless a complete image is resident
  assign memVal    = cpu_rst_q ? DATA_WIDTH'(NOP_BYTE) : rd_data;

endmodule

// File: tb/tb_program_memory.sv
// Self-checking bench for program_memory: loads, bubbles, full-depth image,
// reload, reset mid-load. Reads are scored against a shadow image.
module tb_program_memory;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] memAddr, memVal, loadLen, loadData;
  logic       loadStart, loadValid, loadReady, loadDone, cpuRst;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_mem [256];
  logic [7:0] exp_q [$];

  // Observations gathered by drive_load
  int         r_ready, r_cycles, r_done_early, r_done_cnt, r_nop_bad;
  logic       r_done_first, r_cpurst_first, r_ready_after;
  logic [7:0] r_fetch0;

  always #5 clk = ~clk;

  program_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .memAddr(memAddr), .memVal(memVal),
    .loadStart(loadStart), .loadLen(loadLen), .loadData(loadData),
    .loadValid(loadValid), .loadReady(loadReady), .loadDone(loadDone),
    .cpuRst(cpuRst)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc; @(posedge clk); #1; endtask
  task automatic smp; @(negedge clk); endtask

  // Stream an image of n bytes. In LOAD a byte is accepted whenever valid is
  // high; with bubble set, valid alternates 1,0,1,... A loadStart with a
  // different length can be injected at LOAD cycle extra_start.
  task automatic drive_load(input int n, input logic [7:0] len_field,
                            input logic [7:0] data [$], input bit bubble,
                            input int extra_start);
    int idx, c;
    r_ready = 0; r_done_early = 0; r_done_cnt = 0; r_nop_bad = 0;
    cyc;
    loadStart = 1'b1; loadLen = len_field;
    loadValid = 1'b1; loadData = 8'hEE;  // must not be accepted
    smp;
    cyc;
    loadStart = 1'b0;
    idx = 0; c = 0;
    while (idx < n) begin
      loadValid = bubble ? (c % 2 == 0) : 1'b1;
      loadData  = data[idx];
      loadStart = (c == extra_start);
      loadLen   = 8'd3;
      memAddr   = 8'(c * 7);
      smp;
      if (loadReady === 1'b1) r_ready++;
      if (loadDone !== 1'b0) r_done_early++;
      if (memVal !== 8'h00 || cpuRst !== 1'b1) r_nop_bad++;
      if (loadValid) begin
        model_mem[idx[7:0]] = data[idx];
        idx++;
      end
      c++;
      cyc;
    end
    r_cycles  = c;
    loadValid = 1'b0; loadStart = 1'b0; memAddr = 8'h00;
    smp;
    r_done_first   = loadDone;
    r_cpurst_first = cpuRst;
    r_ready_after  = loadReady;
    r_fetch0       = memVal;
    r_done_cnt     = (loadDone === 1'b1) ? 1 : 0;
    for (int k = 0; k < 3; k++) begin
      cyc; smp;
      if (loadDone === 1'b1) r_done_cnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; loadStart = 1'b0; loadValid = 1'b0;
    loadLen = 8'h00; loadData = 8'h00; memAddr = 8'h00;
    cyc; cyc;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc;
      memAddr   = 8'($urandom_range(0, 255));
      loadValid = (i % 3 == 0);
      loadData  = 8'hC3;
      smp;
      checks++;
      if ({cpuRst, loadReady, loadDone} !== 3'b100) begin
        errors++;
        $display("FAIL reset_ctrl cyc %0d: cpuRst/ready/done = %b, expected 100", i, {cpuRst, loadReady, loadDone});
      end
      checks++;
      if (memVal !== 8'h00) begin
        errors++;
        $display("FAIL reset_nop addr %h: memVal %h, expected 00", memAddr, memVal);
      end
    end
    loadValid = 1'b0;
  endtask

  task automatic test_load_b2b;
    logic [7:0] d [$];
    d = '{8'h11, 8'h5A, 8'h03, 8'h60};
    drive_load(4, 8'd4, d, 1'b0, -1);
    checks++; if (r_ready !== 4) begin errors++; $display("FAIL b2b_ready_cycles: got %0d expected 4", r_ready); end
    checks++; if (r_nop_bad !== 0 || r_done_early !== 0) begin errors++; $display("FAIL b2b_during_load: nop_bad %0d done_early %0d expected 0 0", r_nop_bad, r_done_early); end
    checks++; if ({r_done_first, r_cpurst_first, r_ready_after} !== 3'b100) begin errors++; $display("FAIL b2b_done_edge: done/cpuRst/ready %b expected 100", {r_done_first, r_cpurst_first, r_ready_after}); end
    checks++; if (r_done_cnt !== 1) begin errors++; $display("FAIL b2b_done_count: got %0d expected 1", r_done_cnt); end
    checks++; if (r_fetch0 !== 8'h11) begin errors++; $display("FAIL b2b_first_fetch: got %h expected 11", r_fetch0); end
    for (int a = 0; a < 4; a++) begin
      logic [7:0] e;
      cyc; memAddr = 8'(a); exp_q.push_back(model_mem[a]);
      smp; e = exp_q.pop_front();
      checks++; if (memVal !== e) begin errors++; $display("FAIL b2b_read addr %0d: got %h expected %h", a, memVal, e); end
    end
  endtask

  task automatic test_load_bubble;
    logic [7:0] d [$];
    d = '{8'h11, 8'h5A, 8'h03, 8'h60};
    drive_load(4, 8'd4, d, 1'b1, -1);
    checks++; if (r_cycles !== 7 || r_ready !== 7) begin errors++; $display("FAIL bubble_ready_cycles: got %0d/%0d expected 7/7", r_ready, r_cycles); end
    checks++; if (r_nop_bad !== 0 || r_done_early !== 0) begin errors++; $display("FAIL bubble_during_load: nop_bad %0d done_early %0d expected 0 0", r_nop_bad, r_done_early); end
    checks++; if ({r_done_first, r_cpurst_first} !== 2'b10 || r_done_cnt !== 1) begin errors++; $display("FAIL bubble_done: done/cpuRst %b count %0d expected 10 1", {r_done_first, r_cpurst_first}, r_done_cnt); end
    for (int a = 0; a < 4; a++) begin
      logic [7:0] e;
      cyc; memAddr = 8'(a); exp_q.push_back(model_mem[a]);
      smp; e = exp_q.pop_front();
      checks++; if (memVal !== e) begin errors++; $display("FAIL bubble_read addr %0d: got %h expected %h", a, memVal, e); end
    end
  endtask

  task automatic test_full_load;
    logic [7:0] d [$];
    logic [7:0] addrs [$];
    for (int i = 0; i < 256; i++) d.push_back(8'(i));
    // extra loadStart lands in the fifth cycle counted from the start pulse
    drive_load(256, 8'd0, d, 1'b0, 3);
    checks++; if (r_ready !== 256) begin errors++; $display("FAIL full_ready_cycles: got %0d expected 256", r_ready); end
    checks++; if (r_nop_bad !== 0 || r_done_early !== 0) begin errors++; $display("FAIL full_during_load: nop_bad %0d done_early %0d expected 0 0", r_nop_bad, r_done_early); end
    checks++; if ({r_done_first, r_cpurst_first} !== 2'b10 || r_done_cnt !== 1) begin errors++; $display("FAIL full_done: done/cpuRst %b count %0d expected 10 1", {r_done_first, r_cpurst_first}, r_done_cnt); end
    addrs = '{8'h00, 8'h03, 8'h04, 8'h80, 8'hFE, 8'hFF};
    foreach (addrs[j]) begin
      logic [7:0] e;
      cyc; memAddr = addrs[j]; exp_q.push_back(model_mem[addrs[j]]);
      smp; e = exp_q.pop_front();
      checks++; if (memVal !== e) begin errors++; $display("FAIL full_read addr %h: got %h expected %h", addrs[j], memVal, e); end
    end
    // Stray valid bytes in RUN must not be written anywhere
    for (int k = 0; k < 3; k++) begin
      cyc; loadValid = 1'b1; loadData = 8'hEE;
    end
    cyc; loadValid = 1'b0;
    for (int a = 0; a < 2; a++) begin
      logic [7:0] e;
      cyc; memAddr = 8'(a); exp_q.push_back(model_mem[a]);
      smp; e = exp_q.pop_front();
      checks++; if (memVal !== e) begin errors++; $display("FAIL run_valid_ignored addr %0d: got %h expected %h", a, memVal, e); end
    end
  endtask

  task automatic test_reload;
    logic [7:0] d [$];
    d = '{8'hAA, 8'hBB};
    drive_load(2, 8'd2, d, 1'b0, -1);
    checks++; if (r_ready !== 2) begin errors++; $display("FAIL reload_ready_cycles: got %0d expected 2", r_ready); end
    checks++; if (r_nop_bad !== 0) begin errors++; $display("FAIL reload_nop_cpurst: %0d bad cycles expected 0", r_nop_bad); end
    checks++; if ({r_done_first, r_cpurst_first} !== 2'b10 || r_done_cnt !== 1) begin errors++; $display("FAIL reload_done: done/cpuRst %b count %0d expected 10 1", {r_done_first, r_cpurst_first}, r_done_cnt); end
    for (int a = 0; a < 3; a++) begin
      logic [7:0] e;
      cyc; memAddr = 8'(a); exp_q.push_back(model_mem[a]);
      smp; e = exp_q.pop_front();
      checks++; if (memVal !== e) begin errors++; $display("FAIL reload_read addr %0d: got %h expected %h", a, memVal, e); end
    end
  endtask

  task automatic test_rst_mid_load;
    logic [7:0] d [$];
    int dones;
    cyc; loadStart = 1'b1; loadLen = 8'd4; loadValid = 1'b0;
    cyc; loadStart = 1'b0; loadValid = 1'b1; loadData = 8'h21;
    cyc; loadData = 8'h22;
    model_mem[0] = 8'h21; model_mem[1] = 8'h22;
    cyc; loadValid = 1'b0; rst = 1'b1;
    cyc; rst = 1'b0;
    smp;
    checks++; if ({cpuRst, loadReady, loadDone} !== 3'b100 || memVal !== 8'h00) begin errors++; $display("FAIL rst_mid_load: cpuRst/ready/done %b memVal %h expected 100 00", {cpuRst, loadReady, loadDone}, memVal); end
    dones = 0;
    for (int k = 0; k < 5; k++) begin
      cyc; smp;
      if (loadDone !== 1'b0 || cpuRst !== 1'b1) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL rst_no_done: %0d bad cycles expected 0", dones); end
    d = '{8'h31, 8'h32, 8'h33, 8'h34};
    drive_load(4, 8'd4, d, 1'b0, -1);
    checks++; if (r_ready !== 4 || {r_done_first, r_cpurst_first} !== 2'b10 || r_done_cnt !== 1) begin errors++; $display("FAIL after_rst_load: ready %0d done/cpuRst %b count %0d expected 4 10 1", r_ready, {r_done_first, r_cpurst_first}, r_done_cnt); end
    for (int a = 0; a < 6; a++) begin
      logic [7:0] e;
      cyc; memAddr = 8'(a); exp_q.push_back(model_mem[a]);
      smp; e = exp_q.pop_front();
      checks++; if (memVal !== e) begin errors++; $display("FAIL after_rst_read addr %0d: got %h expected %h", a, memVal, e); end
    end
  endtask

  initial begin
    test_reset;
    test_load_b2b;
    test_load_bubble;
    test_full_load;
    test_reload;
    test_rst_mid_load;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_memory.md
# program_memory

Instruction memory and boot loader feeding the CPU control unit. It answers the control unit's instruction fetch by returning the byte at the program-counter address in the same cycle. It also accepts a program image as a byte stream over a valid/ready handshake. While a program is loading, it holds the CPU in reset and presents NOP to the fetch port.

## Interface
- ADDR_WIDTH, 8, fetch/write address width; depth is 2**ADDR_WIDTH bytes.
- DATA_WIDTH, 8, instruction width: opcode [7:3], register/operand field [2:0].

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- memAddr  input  ADDR_WIDTH  fetch address from the program counter.
- memVal  output  DATA_WIDTH  fetched instruction byte.
- loadStart  input  1  one-cycle request to begin loading a program image.
- loadLen  input  ADDR_WIDTH  image length in bytes, sampled with loadStart; 0 means 2**ADDR_WIDTH bytes.
- loadData  input  DATA_WIDTH  image byte.
- loadValid  input  1  loadData is valid.
- loadReady  output  1  block accepts a byte this cycle.
- loadDone  output  1  one-cycle pulse after the last image byte is written.
- cpuRst  output  1  reset for the CPU (program counter and control unit), active-high.

## Operation
- FSM states are IDLE, LOAD and RUN.
- Reset (rst=1) forces:
  - state = IDLE, cpuRst = 1, loadReady = 0, loadDone = 0;
  - write pointer = 0, remaining count = 0.
- Reset does not clear the memory array; its contents persist across rst.
- IDLE:
  - cpuRst = 1; memVal = 0x00.
  - loadStart moves to LOAD.
  - Nothing else leaves IDLE. The CPU never runs until a load completes.
- LOAD is entered from IDLE or RUN on loadStart:
  - Latch remaining = (loadLen == 0) ? 2**ADDR_WIDTH : loadLen. The counter is ADDR_WIDTH+1 bits wide.
  - Clear the write pointer.
  - loadReady = 1 for the whole state.
  - On each cycle with loadValid & loadReady:
    - mem[wrPtr] <= loadData;
    - wrPtr increments, wrapping modulo depth;
    - remaining decrements.
  - When the byte that brings remaining to 0 is accepted, go to RUN on the next edge and pulse loadDone in that first RUN cycle.
- RUN:
  - cpuRst = 0; loadReady = 0.
  - memVal = mem[memAddr], combinational.
  - loadStart re-enters LOAD (reload).
- memVal is forced to 0x00 (NOP) in IDLE and LOAD, so a fetch never sees a partially written image.
- Bytes at addresses at or beyond the image length keep their previous contents.
- Boundary behaviour:
  - loadStart while already in LOAD is ignored; loadLen is not re-sampled.
  - loadValid outside LOAD is ignored and nothing is written.
  - loadStart and loadValid in the same cycle in IDLE/RUN: only the state change happens; that byte is not accepted, because loadReady is 0 in that cycle.
  - rst during LOAD returns to IDLE. Bytes already written remain in memory, no loadDone is produced, and cpuRst stays 1.
  - rst has priority over loadStart in the same cycle.

## Timing
- Fetch latency is 0 cycles: memVal follows memAddr combinationally in RUN.
- A write accepted at edge N is visible on memVal from cycle N+1 (write-then-read, no bypass).
- All control outputs (cpuRst, loadReady, loadDone) are registered state decodes and glitch-free.
- Load of L bytes with loadValid held high takes:
  - 1 cycle for the IDLE/RUN→LOAD edge;
  - L accept cycles;
  - 1 cycle to reach RUN.
- cpuRst falls on the same edge that loadDone rises. The CPU's first fetch, at address 0, happens in that cycle.
- loadReady is 1 from the first LOAD cycle through the cycle in which the last byte is accepted.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants OP_NOP=5'b00000, OP_MOV_RX_R0=5'b00001, OP_MOV_CONST_R0=5'b00010, OP_MOV_R0_RX=5'b00011, OP_NOT=5'b00111, OP_AND=5'b01000, OP_OR=5'b01001, OP_XOR=5'b01010, OP_ADD=5'b01011, OP_SUB=5'b01100;
  - the NOP_BYTE constant 8'h00;
  - the loader state enum (IDLE, LOAD, RUN).
- One sub-module, instr_ram: write-synchronous, read-asynchronous array with one write port and one read port. The FSM, counters and output muxing live in program_memory.

## Test plan
- Reset then no loadStart for 20 cycles → cpuRst=1, loadReady=0, memVal=0x00 for any memAddr.
- loadStart with loadLen=4, stream 0x11,0x5A,0x03,0x60 back-to-back:
  - loadReady high for 4 accept cycles;
  - loadDone pulses exactly once and cpuRst falls in that cycle;
  - memAddr 0..3 then read 0x11,0x5A,0x03,0x60.
- Same load with loadValid toggling 1,0,1,0… → identical memory contents; loadDone is delayed by the bubble cycles only.
- loadLen=0 with 256 bytes i → 256 accepts, memVal at 0xFF is 0xFF; a fifth-cycle loadStart during LOAD has no effect.
- Reload in RUN with loadLen=2 (0xAA,0xBB) → cpuRst=1 and memVal=0x00 during LOAD; afterwards addresses 0..1 read 0xAA,0xBB and address 2 keeps its old value.
- rst asserted after 2 of 4 bytes → IDLE, no loadDone, cpuRst=1. A following full load then completes normally.
